// File: rtl/go_scheduler_if.sv
// ---------------------------------------------------------------------------
// go_scheduler_if
//   Request channel into the go_scheduler tag queue.
//
//   req_valid  request present this cycle
//   req_tag    tag carried with the request (TAG_W bits)
//   req_ready  queue can accept; a transfer happens when req_valid and
//              req_ready are both high at a rising clock edge
//
//   master : request producer
//   slave  : go_scheduler
// ---------------------------------------------------------------------------
interface go_scheduler_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready;

  modport master (
    output req_valid,
    output req_tag,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_tag,
    output req_ready
  );
endinterface

// File: rtl/go_scheduler.sv
// ---------------------------------------------------------------------------
// go_scheduler
//   Queues request tags and launches them one at a time on a downstream
//   4-state sequencer. A job is launched with a one-cycle go pulse only while
//   the sequencer reports idle, and is retired with a one-cycle done pulse
//   once the sequencer reaches its last state. If the sequencer drops back to
//   idle mid-run the job is abandoned and a sticky error is raised.
//
// Parameters
//   DEPTH  tag queue depth in entries (power of two, 2..16)
//   TAG_W  tag width in bits
//
// Ports
//   clock       single clock, rising edge
//   reset       synchronous, active-low
//   req         go_scheduler_if.slave request channel (valid/tag/ready)
//   fsm_state   current state of the downstream sequencer (0 = idle)
//   go          registered one-cycle start pulse
//   active_tag  tag of the job being issued or run; holds its last value
//   busy        scheduler is not idle
//   done        registered one-cycle completion pulse (active_tag valid)
//   err         sticky protocol-error flag
//   pending     number of queued, unissued tags
//   done_cnt    saturating completed-job count
//
// Build option
//   GO_SCHED_STATS_EN  when defined, done_cnt counts done pulses and
//                      saturates at 255; otherwise done_cnt is tied to 0.
// ---------------------------------------------------------------------------
module go_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  go_scheduler_if.slave          req,
  input  logic [1:0]             fsm_state,
  output logic                   go,
  output logic [TAG_W-1:0]       active_tag,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [$clog2(DEPTH):0] pending,
  output logic [7:0]             done_cnt
);

  localparam int             AW   = $clog2(DEPTH);
  localparam int             CW   = AW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [TAG_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic              push;
  logic              pop;
  logic              go_nxt;
  logic              done_nxt;
  logic              err_set;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never opens an extra slot combinationally.
  assign req.req_ready = (count < FULL);
  assign push          = req.req_valid && req.req_ready;
  assign pending       = count;
  assign busy          = (state != IDLE);

  // ---- scheduler next-state / pulse decode ----
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    go_nxt    = 1'b0;
    done_nxt  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        // count is registered: a tag pushed this cycle cannot be popped
        // until the next one.
        if ((count != '0) && (fsm_state == 2'd0)) begin
          pop       = 1'b1;
          go_nxt    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (fsm_state == 2'd3) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (fsm_state == 2'd0) begin
          // Sequencer fell back to idle without finishing: drop the job.
          err_set   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      go         <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      active_tag <= '0;
    end else begin
      state <= state_nxt;
      go    <= go_nxt;
      done  <= done_nxt;
      if (err_set) begin
        err <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        active_tag <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- tag storage (data only, no reset) ----
  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem[wr_ptr] <= req.req_tag;
    end
  end

`ifdef GO_SCHED_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] done_cnt_q;

  // ---- completion statistics ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      done_cnt_q <= 8'd0;
    end else if (done) begin
      done_cnt_q <= sat_inc8(done_cnt_q);
    end
  end

  assign done_cnt = done_cnt_q;
`else
  assign done_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_go_scheduler.sv
// ---------------------------------------------------------------------------
// tb_go_scheduler
//   Self-checking bench for go_scheduler. A job-lifecycle reference model
//   (tag queue plus "cycles since issue" age) predicts every output each
//   cycle; directed sequences cover launch timing, back-pressure, go
//   spacing, sequencer abort and reset, followed by randomized traffic.
//   A reference 4-state sequencer answers go pulses and can be overridden.
// ---------------------------------------------------------------------------
module tb_go_scheduler;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [1:0]             fsm_state;
  logic                   go;
  logic [TAG_W-1:0]       active_tag;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [$clog2(DEPTH):0] pending;
  logic [7:0]             done_cnt;

  go_scheduler_if #(.TAG_W(TAG_W)) ifc();

  go_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (ifc.slave),
    .fsm_state  (fsm_state),
    .go         (go),
    .active_tag (active_tag),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pending    (pending),
    .done_cnt   (done_cnt)
  );

  always #5 clock = ~clock;

  // Reference sequencer: leaves idle on go, then walks 1,2,3 and back to 0.
  logic [1:0] seq_st = 2'd0;
  logic       seq_force;
  logic [1:0] seq_val;
  assign fsm_state = seq_force ? seq_val : seq_st;

  always @(posedge clock) begin
    if (seq_st == 2'd0) seq_st <= go ? 2'd1 : 2'd0;
    else                seq_st <= seq_st + 2'd1;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // ---- reference model ----
  int mq[$];
  int m_age = -1;   // -1 no job, 0 go cycle, >=1 running
  bit m_go, m_done, m_err;
  int m_tag, m_cnt;
  int done_log[$];

  function automatic int exp_cnt();
`ifdef GO_SCHED_STATS_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    bit acc;
    if (!reset) begin
      mq.delete();
      m_age = -1; m_go = 0; m_done = 0; m_err = 0; m_tag = 0; m_cnt = 0;
    end else begin
      acc = ifc.req_valid && (mq.size() < DEPTH);
      if (m_done && m_cnt < 255) m_cnt++;
      m_go = 0;
      m_done = 0;
      if (m_age < 0) begin
        if (mq.size() > 0 && fsm_state == 2'd0) begin
          m_tag = mq.pop_front();
          m_age = 0;
          m_go  = 1;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (fsm_state == 2'd3) begin
        m_age  = -1;
        m_done = 1;
      end else if (fsm_state == 2'd0) begin
        m_age = -1;
        m_err = 1;
      end
      if (acc) mq.push_back(int'(ifc.req_tag));
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (mon_en) begin
      chk("pending",   32'(pending),        32'(mq.size()));
      chk("req_ready", 32'(ifc.req_ready),  32'(mq.size() < DEPTH));
      chk("go",        32'(go),             32'(m_go));
      chk("busy",      32'(busy),           32'(m_age >= 0));
      chk("done",      32'(done),           32'(m_done));
      chk("err",       32'(err),            32'(m_err));
      chk("active_tag",32'(active_tag),     32'(m_tag));
      chk("done_cnt",  32'(done_cnt),       32'(exp_cnt()));
      if (done) done_log.push_back(int'(active_tag));
    end
  end

  // ---- stimulus helpers (called at a negedge, return at a negedge) ----
  task automatic push_tag(input int tag);
    bit acc;
    ifc.req_valid = 1'b1;
    ifc.req_tag   = TAG_W'(tag);
    for (int i = 0; i < 60; i++) begin
      acc = ifc.req_ready;
      @(negedge clock);
      if (acc) return;
    end
    chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_go();
    for (int i = 0; i < 60; i++) begin
      if (go) return;
      @(negedge clock);
    end
    chk("go_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && pending == 0 && fsm_state == 2'd0 && !done) return;
      @(negedge clock);
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  int go_cyc[$];

  initial begin
    reset         = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_tag   = '0;
    seq_force     = 1'b0;
    seq_val       = 2'd0;

    // reset held two cycles
    repeat (2) @(negedge clock);
    chk("rst_go",      32'(go),            32'd0);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_pending", 32'(pending),       32'd0);
    chk("rst_ready",   32'(ifc.req_ready), 32'd1);
    chk("rst_done",    32'(done),          32'd0);
    chk("rst_err",     32'(err),           32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // single job launch timing
    @(negedge clock);
    ifc.req_valid = 1'b1;
    ifc.req_tag   = 4'd5;
    @(negedge clock);
    ifc.req_valid = 1'b0;
    chk("t1_pending", 32'(pending), 32'd1);
    chk("t1_go",      32'(go),      32'd0);
    @(negedge clock);
    chk("t2_go",      32'(go),      32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk("run_go",  32'(go),        32'd0);
      chk("run_fsm", 32'(fsm_state), 32'(k));
    end
    @(negedge clock);
    chk("t6_done", 32'(done),       32'd1);
    chk("t6_tag",  32'(active_tag), 32'd5);

    // go spacing with two queued tags
    push_tag(2);
    push_tag(3);
    ifc.req_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (go) go_cyc.push_back(cyc);
      @(negedge clock);
    end
    chk("go_count", 32'(go_cyc.size()), 32'd2);
    if (go_cyc.size() == 2) chk("go_spacing", 32'(go_cyc[1] - go_cyc[0]), 32'd5);
    wait_idle();

    // back-pressure with the sequencer held busy, then in-order drain
    done_log.delete();
    seq_force = 1'b1;
    seq_val   = 2'd2;
    for (int t = 1; t <= 4; t++) push_tag(t);
    ifc.req_valid = 1'b1;
    ifc.req_tag   = 4'd5;
    chk("full_ready",   32'(ifc.req_ready), 32'd0);
    chk("full_pending", 32'(pending),       32'd4);
    repeat (3) begin
      @(negedge clock);
      chk("stall_pending", 32'(pending), 32'd4);
      chk("stall_go",      32'(go),      32'd0);
    end
    seq_force = 1'b0;
    push_tag(5);
    ifc.req_valid = 1'b0;
    wait_idle();
    chk("order_len", 32'(done_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < done_log.size()) chk("order_tag", 32'(done_log[i]), 32'(i + 1));

    // sequencer abort during RUN
    push_tag(7);
    push_tag(8);
    ifc.req_valid = 1'b0;
    wait_go();
    @(negedge clock);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    seq_force = 1'b1;
    seq_val   = 2'd0;
    @(negedge clock);
    seq_force = 1'b0;
    chk("abort_err",  32'(err),  32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clock);
    wait_go();
    chk("abort_next_tag", 32'(active_tag), 32'd8);
    wait_idle();
    chk("err_sticky", 32'(err), 32'd1);

    // statistics and reset during RUN with three tags pending
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    push_tag(1);
    push_tag(2);
    push_tag(3);
    ifc.req_valid = 1'b0;
    wait_idle();
`ifdef GO_SCHED_STATS_EN
    chk("stats_three", 32'(done_cnt), 32'd3);
`else
    chk("stats_off", 32'(done_cnt), 32'd0);
`endif
    for (int t = 10; t < 14; t++) push_tag(t);
    ifc.req_valid = 1'b0;
    chk("pre_rst_busy",    32'(busy),    32'd1);
    chk("pre_rst_pending", 32'(pending), 32'd3);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("mid_rst_pending", 32'(pending),  32'd0);
    chk("mid_rst_busy",    32'(busy),     32'd0);
    chk("mid_rst_go",      32'(go),       32'd0);
    chk("mid_rst_cnt",     32'(done_cnt), 32'd0);
    @(negedge clock);
    chk("post_rst_ready",  32'(ifc.req_ready), 32'd1);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ifc.req_valid = 1'($urandom % 2);
      ifc.req_tag   = TAG_W'($urandom);
      seq_force     = ($urandom % 16) == 0;
      seq_val       = 2'($urandom);
      reset         = !(($urandom % 500) == 0);
      @(negedge clock);
    end
    ifc.req_valid = 1'b0;
    seq_force     = 1'b0;
    reset         = 1'b1;
    repeat (40) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
